// File: rtl/countdown_spi_display.sv
// BCD countdown with load/start/pause control and a write-only SPI master that
// sends the count as ASCII digits (most significant digit first) after every change.
module countdown_spi_display #(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_tick,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   i_load_value,
  input  logic                  i_start,
  input  logic                  i_pause,
  output logic [4*DIGITS-1:0]   o_count,
  output logic                  o_zero,
  output logic                  o_done,
  output logic                  o_busy,
  output logic                  o_ss,
  output logic                  o_sclk,
  output logic                  o_mosi
);

  localparam int CW    = 4 * DIGITS;
  localparam int FW    = 8 * DIGITS;
  localparam int DIV_W = $clog2(2 * CLK_DIV + 1);
  localparam int BIT_W = $clog2(FW + 1);

  localparam logic [DIV_W-1:0] HALF_END = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] HOLD_END = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FW - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} cnt_state_t;
  typedef enum logic [1:0] {T_IDLE, T_SETUP, T_SHIFT, T_HOLD} tx_state_t;

  cnt_state_t        r_state;
  tx_state_t         r_tx_state;
  logic [CW-1:0]     r_count;
  logic              r_zero;
  logic              r_done;
  logic              r_pending;
  logic              r_ss;
  logic              r_sclk;
  logic [FW-1:0]     r_shift;
  logic [DIV_W-1:0]  r_div;
  logic [BIT_W-1:0]  r_bit;

  logic [CW-1:0]     w_load_sat;
  logic [CW-1:0]     w_count_dec;
  logic [DIGITS-1:0] w_borrow;
  logic [FW-1:0]     w_frame;
  logic              w_tick_fire;
  logic              w_req;
  logic              w_frame_start;

  // Per-digit datapath: load saturation, borrow-chain decrement, ASCII encoding.
  assign w_borrow[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign w_load_sat[4*gi +: 4] =
        (i_load_value[4*gi +: 4] > 4'd9) ? 4'd9 : i_load_value[4*gi +: 4];

      assign w_count_dec[4*gi +: 4] =
        !w_borrow[gi]                ? r_count[4*gi +: 4] :
        (r_count[4*gi +: 4] == 4'd0) ? 4'd9 :
                                       r_count[4*gi +: 4] - 4'd1;

      assign w_frame[8*gi +: 8] = {4'h3, r_count[4*gi +: 4]};

      if (gi < DIGITS - 1) begin : g_borrow
        assign w_borrow[gi+1] = w_borrow[gi] && (r_count[4*gi +: 4] == 4'd0);
      end
    end
  endgenerate

  assign w_tick_fire   = i_tick && !i_load && !i_pause && !i_start && (r_state == S_RUN);
  assign w_req         = i_load || w_tick_fire;
  assign w_frame_start = (r_tx_state == T_IDLE) && r_pending;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_zero  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_load) begin
        r_state <= S_IDLE;
        r_count <= w_load_sat;
        r_zero  <= (w_load_sat == '0);
      end else if (i_pause) begin
        if (r_state == S_RUN)
          r_state <= S_PAUSED;
      end else if (i_start) begin
        if (r_state == S_IDLE || r_state == S_PAUSED)
          r_state <= (r_count == '0) ? S_DONE : S_RUN;
      end else if (w_tick_fire) begin
        r_count <= w_count_dec;
        r_zero  <= (w_count_dec == '0);
        if (w_count_dec == '0) begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
      end
    end
  end

  // A request arriving in the same cycle a frame starts must survive the clear.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= w_req || (r_pending && !w_frame_start);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_tx_state <= T_IDLE;
      r_ss       <= 1'b1;
      r_sclk     <= 1'b0;
      r_shift    <= '0;
      r_div      <= '0;
      r_bit      <= '0;
    end else begin
      case (r_tx_state)
        T_IDLE: begin
          if (r_pending) begin
            r_shift    <= w_frame;
            r_ss       <= 1'b0;
            r_div      <= '0;
            r_bit      <= '0;
            r_tx_state <= T_SETUP;
          end
        end
        T_SETUP: begin
          if (r_div == HALF_END) begin
            r_div      <= '0;
            r_tx_state <= T_SHIFT;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        T_SHIFT: begin
          if (r_div == HALF_END) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
            // Falling edge: advance data; the final shift leaves mosi low.
            if (r_sclk) begin
              r_shift <= {r_shift[FW-2:0], 1'b0};
              if (r_bit == LAST_BIT) begin
                r_tx_state <= T_HOLD;
              end else begin
                r_bit <= r_bit + 1'b1;
              end
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        T_HOLD: begin
          if (r_div == HOLD_END) begin
            r_div      <= '0;
            r_tx_state <= T_IDLE;
          end else begin
            r_div <= r_div + 1'b1;
            if (r_div == HALF_END)
              r_ss <= 1'b1;
          end
        end
        default: r_tx_state <= T_IDLE;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_zero  = r_zero;
  assign o_done  = r_done;
  assign o_ss    = r_ss;
  assign o_busy  = ~r_ss;
  assign o_sclk  = r_sclk;
  assign o_mosi  = r_shift[FW-1];

endmodule
